// File: rtl/lc3_pkg.sv
// LC-3 shared types: register index, data word, condition-code triple.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package lc3_pkg;

    localparam int REG_W    = 16;
    localparam int NUM_REGS = 8;

    typedef logic [2:0]       reg_idx_t;
    typedef logic [REG_W-1:0] word_t;

    typedef struct packed {
        logic n;
        logic z;
        logic p;
    } cc_t;

    // Condition codes a word would set. Exactly one of n/z/p is high.
    // Also used by the branch-enable logic, so it stays a pure function.
    function automatic cc_t cc_from_word(input word_t w);
        cc_t c;
        c = '0;
        if (w[REG_W-1]) begin
            c.n = 1'b1;
        end else if (w == '0) begin
            c.z = 1'b1;
        end else begin
            c.p = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/nzp_reg.sv
// NZP condition-code register; reloads from a word when i_load is high.
// Latency: o_cc reflects i_word one rising edge after i_load is sampled.
// Backpressure: none, accepts a load every cycle.
module nzp_reg
    import lc3_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_load,
    input  word_t i_word,
    output cc_t   o_cc
);

    cc_t r_cc;

    // Hold the condition codes; clear to 000 on reset, reload on i_load.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cc <= '0;
        end else if (i_load) begin
            r_cc <= cc_from_word(i_word);
        end
    end

    assign o_cc = r_cc;

endmodule

// File: rtl/regfile_writer.sv
// LC-3 register-file write side: stages each write for a cycle, then commits R0-R7/NZP.
// Latency: 2 edges LD_REG->R*_Out/NZP (1 edge when REGFILE_BYPASS_EN is defined).
// Backpressure: none, one write per cycle, never stalls.
module regfile_writer
    import lc3_pkg::*;
#(
    // WIDTH must stay equal to lc3_pkg::REG_W; the CC helper works on word_t.
    parameter int WIDTH    = REG_W,
    parameter int NUM_REGS = 8
)(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LD_REG,
    input  logic [2:0]       DR,
    input  logic [WIDTH-1:0] Din,
    input  logic             LD_CC,
    output logic [WIDTH-1:0] R0_Out,
    output logic [WIDTH-1:0] R1_Out,
    output logic [WIDTH-1:0] R2_Out,
    output logic [WIDTH-1:0] R3_Out,
    output logic [WIDTH-1:0] R4_Out,
    output logic [WIDTH-1:0] R5_Out,
    output logic [WIDTH-1:0] R6_Out,
    output logic [WIDTH-1:0] R7_Out,
    output logic             N,
    output logic             Z,
    output logic             P,
    output logic             wr_pending,
    output logic [7:0]       commit_cnt
);

    // Stage register: one write-back held for a cycle before it commits.
    logic             r_stg_vld;
    reg_idx_t         r_stg_dr;
    logic [WIDTH-1:0] r_stg_dat;
    logic             r_stg_cc;

    // Committed architectural state.
    logic [WIDTH-1:0] r_regs [NUM_REGS];
    logic [7:0]       r_commit_cnt;

    // Visible views (committed state, optionally overlaid with the stage).
    logic [WIDTH-1:0] w_view [NUM_REGS];
    cc_t              w_cc_q;
    cc_t              w_cc_view;
    logic             w_cc_load;

    // Capture the incoming write; an idle cycle empties the stage.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_stg_vld <= 1'b0;
            r_stg_dr  <= '0;
            r_stg_dat <= '0;
            r_stg_cc  <= 1'b0;
        end else begin
            r_stg_vld <= LD_REG;
            if (LD_REG) begin
                r_stg_dr  <= DR;
                r_stg_dat <= Din;
                r_stg_cc  <= LD_CC;
            end
        end
    end

    // Commit the staged write into its destination register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_stg_vld) begin
            r_regs[r_stg_dr] <= r_stg_dat;
        end
    end

    // Count commits; wraps naturally at 8 bits.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_commit_cnt <= '0;
        end else if (r_stg_vld) begin
            r_commit_cnt <= r_commit_cnt + 8'd1;
        end
    end

    // CC update rides on the commit and is only taken when the write asked for it.
    assign w_cc_load = r_stg_vld & r_stg_cc;

    nzp_reg u_nzp (
        .i_clk  (Clk),
        .i_rst  (Reset),
        .i_load (w_cc_load),
        .i_word (r_stg_dat),
        .o_cc   (w_cc_q)
    );

    // Register view: committed values, with the staged write forwarded when bypass is built in.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_view[i] = r_regs[i];
        end
`ifdef REGFILE_BYPASS_EN
        if (r_stg_vld) begin
            w_view[r_stg_dr] = r_stg_dat;
        end
`endif
    end

    // CC view: committed NZP, with the staged CC update forwarded when bypass is built in.
    always_comb begin
        w_cc_view = w_cc_q;
`ifdef REGFILE_BYPASS_EN
        if (w_cc_load) begin
            w_cc_view = cc_from_word(r_stg_dat);
        end
`endif
    end

    assign R0_Out     = w_view[0];
    assign R1_Out     = w_view[1];
    assign R2_Out     = w_view[2];
    assign R3_Out     = w_view[3];
    assign R4_Out     = w_view[4];
    assign R5_Out     = w_view[5];
    assign R6_Out     = w_view[6];
    assign R7_Out     = w_view[7];
    assign N          = w_cc_view.n;
    assign Z          = w_cc_view.z;
    assign P          = w_cc_view.p;
    assign wr_pending = r_stg_vld;
    assign commit_cnt = r_commit_cnt;

endmodule

// File: tb/tb_regfile_writer.sv
// Bench for regfile_writer: directed test-plan sequences plus random writes.
// Expected snapshots are queued by the driver and compared by a negedge monitor.
// Build with or without REGFILE_BYPASS_EN; the reference model follows the same macro.
module tb_regfile_writer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        LD_REG;
    logic [2:0]  DR;
    logic [15:0] Din;
    logic        LD_CC;
    logic [15:0] R0_Out, R1_Out, R2_Out, R3_Out, R4_Out, R5_Out, R6_Out, R7_Out;
    logic        N, Z, P;
    logic        wr_pending;
    logic [7:0]  commit_cnt;

    regfile_writer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .LD_REG     (LD_REG),
        .DR         (DR),
        .Din        (Din),
        .LD_CC      (LD_CC),
        .R0_Out     (R0_Out),
        .R1_Out     (R1_Out),
        .R2_Out     (R2_Out),
        .R3_Out     (R3_Out),
        .R4_Out     (R4_Out),
        .R5_Out     (R5_Out),
        .R6_Out     (R6_Out),
        .R7_Out     (R7_Out),
        .N          (N),
        .Z          (Z),
        .P          (P),
        .wr_pending (wr_pending),
        .commit_cnt (commit_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [7:0][15:0] regs;
        logic [2:0]       nzp;
        logic             pend;
        logic [7:0]       cnt;
    } snap_t;

    typedef struct {
        logic [2:0]  dr;
        logic [15:0] d;
        logic        cc;
    } wr_t;

    snap_t sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    snap_no = 0;

    // Reference model: architectural state plus writes accepted but not yet visible.
    logic [15:0] m_regs [8];
    logic [2:0]  m_nzp;
    int          m_cnt;
    wr_t         m_pend[$];

    function automatic logic [2:0] ref_cc(input logic [15:0] v);
        if ($signed(v) < 0)  return 3'b100;
        else if (v == 16'd0) return 3'b010;
        else                 return 3'b001;
    endfunction

    function automatic logic [15:0] rout(input int i);
        case (i)
            0: return R0_Out;
            1: return R1_Out;
            2: return R2_Out;
            3: return R3_Out;
            4: return R4_Out;
            5: return R5_Out;
            6: return R6_Out;
            default: return R7_Out;
        endcase
    endfunction

    task automatic chk(input string name, input int tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at #%0d: actual=%h required=%h", name, tag, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_nzp = 3'b000;
        m_cnt = 0;
        m_pend.delete();
    endtask

    // One rising edge: everything accepted on an earlier edge becomes architectural,
    // then this edge's request (if any) becomes pending.
    task automatic model_edge(input logic ld, input logic [2:0] dr, input logic [15:0] din, input logic cc);
        snap_t s;
        wr_t   w;
        while (m_pend.size() > 0) begin
            w = m_pend.pop_front();
            m_regs[w.dr] = w.d;
            m_cnt = (m_cnt + 1) % 256;
            if (w.cc) m_nzp = ref_cc(w.d);
        end
        if (ld) begin
            w.dr = dr; w.d = din; w.cc = cc;
            m_pend.push_back(w);
        end
        for (int i = 0; i < 8; i++) s.regs[i] = m_regs[i];
        s.nzp  = m_nzp;
        s.pend = (m_pend.size() > 0);
        s.cnt  = m_cnt[7:0];
`ifdef REGFILE_BYPASS_EN
        if (m_pend.size() > 0) begin
            s.regs[m_pend[0].dr] = m_pend[0].d;
            if (m_pend[0].cc) s.nzp = ref_cc(m_pend[0].d);
        end
`endif
        sb_q.push_back(s);
    endtask

    // Drive one cycle of stimulus, sampled on the next rising edge.
    task automatic step(input logic ld, input logic [2:0] dr, input logic [15:0] din, input logic cc);
        LD_REG = ld; DR = dr; Din = din; LD_CC = cc;
        @(posedge Clk);
        model_edge(ld, dr, din, cc);
        #1;
        LD_REG = 1'b0; LD_CC = 1'b0;
    endtask

    task automatic check_all_zero(input int tag);
        for (int i = 0; i < 8; i++) chk($sformatf("rst_R%0d", i), tag, rout(i), 16'h0);
        chk("rst_NZP", tag, {13'd0, N, Z, P}, 16'h0);
        chk("rst_wr_pending", tag, {15'd0, wr_pending}, 16'h0);
        chk("rst_commit_cnt", tag, {8'd0, commit_cnt}, 16'h0);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation at each falling edge.
    initial begin
        snap_t s;
        forever begin
            @(negedge Clk);
            if (sb_q.size() > 0) begin
                s = sb_q.pop_front();
                snap_no++;
                for (int i = 0; i < 8; i++) chk($sformatf("R%0d_Out", i), snap_no, rout(i), s.regs[i]);
                chk("NZP", snap_no, {13'd0, N, Z, P}, {13'd0, s.nzp});
                chk("wr_pending", snap_no, {15'd0, wr_pending}, {15'd0, s.pend});
                chk("commit_cnt", snap_no, {8'd0, commit_cnt}, {8'd0, s.cnt});
            end
        end
    end

    initial begin
        int wait_cyc;
        Reset = 1'b1; LD_REG = 1'b0; DR = 3'd0; Din = 16'h0; LD_CC = 1'b0;
        model_clear();
        #1;
        check_all_zero(0);
        #13;
        Reset = 1'b0;

        // Single write with CC: positive value.
        step(1'b1, 3'd3, 16'h1234, 1'b1);
        step(1'b0, 3'd0, 16'h0, 1'b0);
        step(1'b0, 3'd0, 16'h0, 1'b0);

        // Negative then zero into the same register, back to back.
        step(1'b1, 3'd5, 16'h8000, 1'b1);
        step(1'b1, 3'd5, 16'h0000, 1'b1);
        step(1'b0, 3'd0, 16'h0, 1'b0);
        step(1'b0, 3'd0, 16'h0, 1'b0);

        // Write without CC, then a lone LD_CC that must be ignored.
        step(1'b1, 3'd3, 16'h0042, 1'b1);
        step(1'b1, 3'd0, 16'h00FF, 1'b0);
        step(1'b0, 3'd7, 16'h8001, 1'b1);
        step(1'b0, 3'd0, 16'h0, 1'b0);

        // Eight consecutive writes sweeping every index.
        for (int i = 0; i < 8; i++) step(1'b1, i[2:0], 16'hA000 + 16'(i), 1'b0);
        step(1'b0, 3'd0, 16'h0, 1'b0);
        step(1'b0, 3'd0, 16'h0, 1'b0);

        // Reset while a write is staged: it must never commit.
        step(1'b1, 3'd2, 16'hBEEF, 1'b1);
        @(negedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        check_all_zero(1);
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        model_clear();
        step(1'b0, 3'd0, 16'h0, 1'b0);
        step(1'b0, 3'd0, 16'h0, 1'b0);

        // 256 random writes: commit counter wraps back to zero.
        for (int i = 0; i < 256; i++)
            step(1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)));
        step(1'b0, 3'd0, 16'h0, 1'b0);
        @(negedge Clk);
        #1;
        chk("cnt_wrap", 2, {8'd0, commit_cnt}, 16'h0000);

        // Bypass-sensitive directed write, then random traffic with idle gaps.
        step(1'b1, 3'd6, 16'h7777, 1'b0);
        step(1'b0, 3'd0, 16'h0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            logic [15:0] d;
            case ($urandom_range(0, 3))
                0:       d = 16'h0000;
                1:       d = 16'h8000 | 16'($urandom);
                default: d = 16'($urandom);
            endcase
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), d, 1'($urandom_range(0, 1)));
        end
        step(1'b0, 3'd0, 16'h0, 1'b0);
        step(1'b0, 3'd0, 16'h0, 1'b0);

        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 10) begin
            @(posedge Clk);
            wait_cyc++;
        end
        #6;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual=%0d queued required=0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
